// File: rtl/led_fade_pwm_pkg.sv
// Shared register map, control bit positions and reset constants for the
// fading LED PWM device.
package led_fade_pwm_pkg;

    localparam logic [4:0] ADDR_TARGET_BASE = 5'h00;
    localparam logic [4:0] ADDR_CTRL        = 5'h10;
    localparam logic [4:0] ADDR_STEP        = 5'h11;
    localparam logic [4:0] ADDR_PRESCALE    = 5'h12;
    localparam logic [4:0] ADDR_CUR_SEL     = 5'h13;
    localparam logic [4:0] ADDR_CUR_VAL     = 5'h14;
    localparam logic [4:0] ADDR_STATUS      = 5'h15;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_GAMMA = 1;

    localparam logic [7:0] STEP_RST = 8'h01;

    // Square-law perceptual correction: (lvl*lvl)/255, truncated; 255 maps to 255.
    function automatic logic [7:0] gamma_correct(input logic [7:0] lvl);
        logic [15:0] sq;
        sq = 16'(lvl) * 16'(lvl);
        return 8'(sq / 16'd255);
    endfunction

endpackage

// File: rtl/pwm_fade_channel.sv
// One LED channel: saturating fade toward a target, optional gamma correction
// and the registered compare against the shared PWM counter.
module pwm_fade_channel
    import led_fade_pwm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] target_i,
    input  logic [7:0] step_i,
    input  logic       tick_i,
    input  logic       gamma_i,
    input  logic       en_i,
    input  logic [7:0] counter_i,
    output logic [7:0] cur_o,
    output logic       led_o,
    output logic       busy_o
);

    logic [7:0] cur_q, cur_d;
    logic       led_q, led_d;
    logic [8:0] up_sum, dn_diff;
    logic [7:0] duty;

    // NOTE: every signal driven here gets a default before any branch, so no latch is inferred.
    always_comb begin
        up_sum  = {1'b0, cur_q} + {1'b0, step_i};
        dn_diff = {1'b0, cur_q} - {1'b0, step_i};
        cur_d   = cur_q;
        if (step_i == 8'd0) begin
            cur_d = target_i;
        end else if (tick_i) begin
            // Ninth bit catches overflow on the way up and borrow on the way down.
            if (cur_q < target_i) begin
                cur_d = (up_sum > {1'b0, target_i}) ? target_i : up_sum[7:0];
            end else if (cur_q > target_i) begin
                cur_d = (dn_diff[8] || (dn_diff[7:0] < target_i)) ? target_i : dn_diff[7:0];
            end
        end
    end

    always_comb begin
        duty  = gamma_i ? gamma_correct(cur_q) : cur_q;
        led_d = en_i & (counter_i < duty);
    end

    // NOTE: state registers take non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q <= 8'd0;
            led_q <= 1'b0;
        end else begin
            cur_q <= cur_d;
            led_q <= led_d;
        end
    end

    assign cur_o  = cur_q;
    assign led_o  = led_q;
    assign busy_o = (cur_q != target_i);

endmodule

// File: rtl/led_fade_pwm_device.sv
// Memory-mapped multi-channel LED PWM controller with hardware fading:
// bus decode, control registers, shared PWM counter and fade prescaler.
module led_fade_pwm_device
    import led_fade_pwm_pkg::*;
#(
    parameter int         NUM_CH   = 10,
    parameter int         PRESC_W  = 8,
    parameter logic [7:0] CTRL_RST = 8'h03
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        address,
    input  logic              enable,
    input  logic              mode,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic [NUM_CH-1:0] LED
);

    logic [7:0]         target_q [NUM_CH];
    logic [1:0]         ctrl_q;
    logic [7:0]         step_q;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [3:0]         cur_sel_q;
    logic [7:0]         pwm_cnt_q;
    logic [7:0]         data_out_q, data_out_d;

    logic [7:0]         cur [NUM_CH];
    logic [NUM_CH-1:0]  busy;
    logic [7:0]         cur_val;
    logic [7:0]         rd_data;
    logic               wr_en, rd_en, tick;

    assign wr_en = enable & mode;
    assign rd_en = enable & ~mode;
    assign tick  = (presc_cnt_q == presc_q);

    always_comb begin
        presc_cnt_d = presc_cnt_q + 1'b1;
        if (wr_en && (address == ADDR_PRESCALE)) begin
            presc_cnt_d = '0;
        end else if (tick) begin
            presc_cnt_d = '0;
        end
    end

    always_comb begin
        cur_val = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cur_sel_q == 4'(i)) cur_val = cur[i];
        end
    end

    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            if (address == ADDR_TARGET_BASE + 5'(i)) rd_data = target_q[i];
        end
        case (address)
            ADDR_CTRL:     rd_data = {6'b0, ctrl_q};
            ADDR_STEP:     rd_data = step_q;
            ADDR_PRESCALE: rd_data = 8'(presc_q);
            ADDR_CUR_SEL:  rd_data = {4'b0, cur_sel_q};
            ADDR_CUR_VAL:  rd_data = cur_val;
            ADDR_STATUS:   rd_data = {7'b0, |busy};
            default:       ;
        endcase
        data_out_d = rd_en ? rd_data : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q      <= CTRL_RST[1:0];
            step_q      <= STEP_RST;
            presc_q     <= '1;
            cur_sel_q   <= 4'd0;
            pwm_cnt_q   <= 8'd0;
            presc_cnt_q <= '0;
            data_out_q  <= 8'h00;
            // NOTE: the target array is a handful of flops, not a RAM, so it is cleared like any other register.
            for (int i = 0; i < NUM_CH; i++) target_q[i] <= 8'h00;
        end else begin
            pwm_cnt_q   <= pwm_cnt_q + 8'd1;
            presc_cnt_q <= presc_cnt_d;
            data_out_q  <= data_out_d;
            if (wr_en) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (address == ADDR_TARGET_BASE + 5'(i)) target_q[i] <= data_in;
                end
                case (address)
                    ADDR_CTRL:     ctrl_q    <= data_in[1:0];
                    ADDR_STEP:     step_q    <= data_in;
                    ADDR_PRESCALE: presc_q   <= PRESC_W'(data_in);
                    ADDR_CUR_SEL:  cur_sel_q <= data_in[3:0];
                    default:       ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_fade_channel u_ch (
            .clk       (clk),
            .reset     (reset),
            .target_i  (target_q[g]),
            .step_i    (step_q),
            .tick_i    (tick),
            .gamma_i   (ctrl_q[CTRL_GAMMA]),
            .en_i      (ctrl_q[CTRL_EN]),
            .counter_i (pwm_cnt_q),
            .cur_o     (cur[g]),
            .led_o     (LED[g]),
            .busy_o    (busy[g])
        );
    end

    assign data_out = data_out_q;

endmodule

// File: doc/led_fade_pwm_device.md
Name: led_fade_pwm_device

Overview:
Parametrised, memory-mapped multi-channel LED PWM controller. It replaces the fixed 10-channel, gamma-only LED device. It adds:
- a configurable channel count;
- per-channel hardware fading from the current level toward a written target, at a programmable step and rate;
- a global enable and a gamma bypass;
- current-level readback.
It sits on the 8-bit device bus and drives the board LED pins directly.

Parameters:
NUM_CH, 10, number of PWM channels (1..16)
PRESC_W, 8, width of the fade prescaler register and counter
CTRL_RST, 8'h03, reset value of CTRL (bit0 global enable, bit1 gamma enable)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
address  input  5  register address
enable  input  1  bus access strobe
mode  input  1  1 = write, 0 = read (qualified by enable)
data_in  input  8  write data
data_out  output  8  read data
LED  output  NUM_CH  PWM outputs

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high, sampled on posedge clk.
- Reset values:
  - TARGET[i] = 0, CUR[i] = 0
  - CTRL = CTRL_RST, STEP = 1, PRESCALE = all ones, CUR_SEL = 0
  - PWM counter = 0, prescale counter = 0
  - LED = 0, data_out = 0
- Register map (any other address reads 0x00; writes to it are ignored):
  - 0x00..0x0F: TARGET[ch], R/W. For ch >= NUM_CH, reads return 0 and writes are ignored.
  - 0x10: CTRL, R/W. Bit0 = EN, bit1 = GAMMA, bits7:2 read 0.
  - 0x11: STEP, R/W, 8-bit fade increment per tick.
  - 0x12: PRESCALE, R/W, PRESC_W bits, zero-extended on read.
  - 0x13: CUR_SEL, R/W, low 4 bits used.
  - 0x14: CUR_VAL, RO, CUR[CUR_SEL]. Reads 0 if CUR_SEL >= NUM_CH.
  - 0x15: STATUS, RO. Bit0 = 1 while any channel has CUR != TARGET.
- Bus:
  - A write commits on the posedge where enable=1 and mode=1.
  - A read is requested when enable=1 and mode=0. data_out is registered and shows the value on the next cycle (1-cycle latency).
  - data_out is 0x00 in any cycle that follows a cycle with no read.
- PWM:
  - The 8-bit counter increments every clk and wraps 255 -> 0.
  - duty[i] = GAMMA ? (CUR[i]*CUR[i])/255 : CUR[i]. The product is 16 bits; integer divide by 255, truncated, giving an 8-bit result.
  - LED[i] is registered: LED[i] <= EN & (counter < duty[i]). Outputs therefore lag the counter by 1 cycle.
  - duty = 0 gives a constantly-off output. duty = 255 gives 255 of every 256 cycles high.
- Fade engine:
  - The prescale counter increments every clk. A tick fires on the cycle where it equals PRESCALE; the counter then returns to 0.
  - PRESCALE = 0 gives a tick every cycle.
  - A write to PRESCALE clears the prescale counter.
- Fade update on a tick, per channel:
  - If CUR < TARGET: CUR <= min(CUR+STEP, TARGET).
  - If CUR > TARGET: CUR <= max(CUR-STEP, TARGET).
  - Compute with 9-bit arithmetic; no wrap and no overshoot.
- STEP = 0 means instant: CUR <= TARGET every cycle, regardless of tick.
- The fade engine runs even when EN = 0. EN gates only the LED outputs.
- Simultaneous events:
  - A TARGET write in the same cycle as a tick: the tick uses the old TARGET, and the new TARGET applies from the next cycle.
  - Retargeting mid-fade continues from the present CUR; there is no jump.
  - A read of CUR_VAL in the same cycle as a CUR update returns the pre-update value.
- Reset asserted mid-fade returns all state to reset values on that edge. LED is 0 on the following cycle.

Decomposition:
- Package led_fade_pwm_pkg holds:
  - register address localparams (ADDR_TARGET_BASE, ADDR_CTRL, ADDR_STEP, ADDR_PRESCALE, ADDR_CUR_SEL, ADDR_CUR_VAL, ADDR_STATUS);
  - CTRL bit indices (CTRL_EN, CTRL_GAMMA);
  - reset constants (STEP_RST).
- Sub-module pwm_fade_channel, instantiated NUM_CH times in a generate loop. Each instance contains one channel's CUR register, its saturating step logic, its gamma function and its compare against the shared counter. Inputs: target, step, tick, gamma, en, counter. Outputs: cur, led, busy.
- The top level holds the bus decode, the control registers, the PWM counter and the prescaler.

Test Plan:
1. Reset, then read every register -> CTRL=0x03, STEP=0x01, PRESCALE=0xFF, TARGET=0, STATUS=0, LED=0 over a full 256-cycle period.
2. STEP=0, GAMMA=0, TARGET[0]=0x40 -> LED[0] high exactly 64 of every 256 cycles. With GAMMA=1 and TARGET[0]=0x80 -> 64 high cycles. TARGET[0]=0xFF -> 255 high cycles. TARGET[0]=0x10 -> 1 high cycle.
3. PRESCALE=3, STEP=0x30, TARGET[2]=0x80 -> CUR_VAL (CUR_SEL=2) reads 0x30, 0x60, 0x80 on successive ticks, 4 cycles apart. STATUS bit0 goes 1 then 0 after 0x80 is reached. Then TARGET[2]=0x00 -> 0x50, 0x20, 0x00 (no underflow).
4. Mid-fade retarget: at CUR=0x60 while rising, write TARGET=0x10 -> next tick gives 0x30, then 0x10. Separately, a TARGET write coincident with a tick -> the tick applies the old target.
5. CTRL.EN=0 with all channels at 0xFF -> LED=0 throughout, while CUR_VAL keeps fading. EN=1 -> LEDs resume on the next cycle.
6. Assert reset mid-fade -> all state returns to reset values next edge. A write to TARGET[12] with NUM_CH=10 reads back 0. Unmapped address 0x1F reads 0x00. Read latency is exactly 1 cycle.
